// File: rtl/proc_pkg.sv
// Shared core definitions: datapath width, fetch FSM states, default halt
// encoding and the PC step, plus a helper that forces word alignment.
package proc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_STEP            = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Clear the two byte-offset bits so the PC always points at a whole word.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer for the fetch stage. It catches an instruction word
// that returns from memory while decode is stalled, and gives it back once
// the stall releases. Clear has priority (used on redirect), then load,
// then drain.
module if_hold_buf
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  // Buffer register: capture on load, release on drain, drop on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and fills the IF/ID register. Decode stalls are
// absorbed by a one-entry hold buffer; redirects from EX win over stall and
// halt. A word equal to HALT_INSTR stops fetching once it reaches IF/ID;
// any read still in flight at that point is dropped so the halt word is the
// last instruction decode sees.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetch_o / perf_stall_o.
module if_fetch_stage
  import proc_pkg::*;
#(
  parameter int              IMEM_AW    = 10,
  parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc_init_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_en_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [XLEN-1:0]    imem_rdata_i,
  output logic               id_valid_o,
  output logic [XLEN-1:0]    id_instr_o,
  output logic [XLEN-1:0]    id_pc_o,
  output logic [XLEN-1:0]    id_pc4_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_o,
  output logic [31:0]        perf_stall_o,
`endif
  output logic               halted_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_v_q;
  logic [XLEN-1:0] req_pc_q;

  logic            id_valid_q;
  logic [XLEN-1:0] id_instr_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_pc4_q;

  logic            hold_v;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic            fetch_req;
  logic            ret_v;
  logic            load_from_mem;
  logic            load_from_hold;
  logic            id_wr;
  logic [XLEN-1:0] wr_instr;
  logic [XLEN-1:0] wr_pc;
  logic            halt_hit;

  // A read is only worth issuing when running, decode can accept, nothing
  // is being redirected and the hold buffer is free. A returning word is
  // only meaningful while running; after halt the in-flight read is dropped.
  assign fetch_req      = (state_q == S_RUN) & ~stall_i & ~redirect_i & ~hold_v;
  assign ret_v          = req_v_q & (state_q == S_RUN);
  assign load_from_mem  = ret_v & ~stall_i & ~redirect_i;
  assign load_from_hold = hold_v & ~stall_i & ~redirect_i;
  assign id_wr          = load_from_mem | load_from_hold;
  assign wr_instr       = load_from_hold ? hold_instr : imem_rdata_i;
  assign wr_pc          = load_from_hold ? hold_pc    : req_pc_q;
  assign halt_hit       = id_wr & (wr_instr == HALT_INSTR);

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect_i),
    .load_i  (ret_v & stall_i),
    .drain_i (load_from_hold),
    .instr_i (imem_rdata_i),
    .pc_i    (req_pc_q),
    .valid_o (hold_v),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  // Next-state and next-PC selection for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        pc_d    = align_pc(pc_init_i);
      end
      S_RUN: begin
        if (redirect_i) begin
          pc_d = align_pc(redirect_pc_i);
        end else begin
          if (fetch_req) pc_d = pc_q + PC_STEP;
          if (halt_hit)  state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (redirect_i) begin
          state_d = S_RUN;
          pc_d    = align_pc(redirect_pc_i);
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // FSM state, PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= '0;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_v_q <= fetch_req;
      if (fetch_req) req_pc_q <= pc_q;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, else load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
    end else if (redirect_i) begin
      id_valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (id_wr) begin
        id_valid_q <= 1'b1;
        id_instr_q <= wr_instr;
        id_pc_q    <= wr_pc;
        id_pc4_q   <= wr_pc + PC_STEP;
      end else begin
        id_valid_q <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Saturating counters: words delivered to IF/ID and stalled live cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (id_wr && (perf_fetch_q != 32'hFFFF_FFFF))
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall_i && id_valid_q && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

  assign imem_en_o   = fetch_req;
  assign imem_addr_o = pc_q[IMEM_AW+1:2];
  assign id_valid_o  = id_valid_q;
  assign id_instr_o  = id_instr_q;
  assign id_pc_o     = id_pc_q;
  assign id_pc4_o    = id_pc4_q;
  assign halted_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage. The expected instruction stream after each boot
// or redirect is simply "consecutive words from the target until a halt
// word", read from the bench's own memory image and queued; a monitor pops
// one entry whenever a fresh instruction appears in IF/ID.
module tb_if_fetch_stage;

  localparam int          AW   = 10;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc_init = '0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc4;
  logic          halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   perf_fetch;
  logic [31:0]   perf_stall;
`endif

  if_fetch_stage #(.IMEM_AW(AW), .HALT_INSTR(HALT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_init_i     (pc_init),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc4_o      (id_pc4),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_o  (perf_fetch),
    .perf_stall_o  (perf_stall),
`endif
    .halted_o      (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];

  // Synchronous instruction memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   model_halted = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected stream: consecutive aligned words from target, ending at a halt word.
  task automatic loadStream(input logic [31:0] target);
    logic [31:0] pc;
    logic [31:0] w;
    exp_q.delete();
    model_halted = 1'b0;
    pc = target & ~32'd3;
    for (int k = 0; k < 256; k++) begin
      w = mem[pc[AW+1:2]];
      exp_q.push_back('{pc: pc, instr: w});
      if (w == HALT) break;
      pc = pc + 32'd4;
    end
  endtask

  // Monitor: a live IF/ID with no stall at the last edge is a new instruction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (id_valid && !stall) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_instr: got pc %h, expected none (t=%0t)", id_pc, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("id_pc", id_pc, e.pc);
          checkOutput("id_instr", id_instr, e.instr);
          checkOutput("id_pc4", id_pc4, e.pc + 32'd4);
          if (e.instr == HALT) model_halted = 1'b1;
        end
      end
      checkOutput("halted", {31'd0, halted}, {31'd0, model_halted});
      if (model_halted) checkOutput("imem_en_halted", {31'd0, imem_en}, 32'd0);
    end
  end

  task automatic applyStimulus(input bit s, input bit r, input logic [31:0] tgt);
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_pc = tgt;
    if (r) loadStream(tgt);
  endtask

  // Reset pulse with immediate-clear check, then boot latency check.
  task automatic doReset(input logic [31:0] init);
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    pc_init = init;
    #1;
    checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_pc4", id_pc4, 32'd0);
    checkOutput("rst_imem_en", {31'd0, imem_en}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    exp_q.delete();
    model_halted = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    loadStream(init);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("boot_valid_c%0d", c), {31'd0, id_valid}, (c == 3) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic waitForPc(input logic [31:0] pc, input int budget);
    bit found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(posedge clk);
      #1;
      if (id_valid && id_pc == pc) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL wait_pc: got timeout, expected id_pc %h within %0d cycles", pc, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = i;
    mem[32'h50 >> 2] = HALT;

    // Boot at 500: 500,504,... carrying words 125,126,...
    doReset(32'd500);

    // Stall three cycles while 504 is shown; it must stay put.
    waitForPc(32'd504, 10);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
      checkOutput("stall_hold_pc", id_pc, 32'd504);
    end
    applyStimulus(1'b0, 1'b0, '0);

    // Redirect at 512 to 0x40: two empty cycles, then the target.
    waitForPc(32'd512, 10);
    applyStimulus(1'b0, 1'b1, 32'h40);
    @(posedge clk);
    #1;
    checkOutput("redir_bubble1", {31'd0, id_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    checkOutput("redir_bubble2", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("redir_target_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("redir_target_pc", id_pc, 32'h40);

    // Stall once to fill the hold buffer, then redirect with stall held.
    redirect_pc = '0;
    applyStimulus(1'b0, 1'b1, 32'h100);
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'h203);
    repeat (6) applyStimulus(1'b0, 1'b0, '0);

    // Halt at 0x50, then resume at 0x60.
    applyStimulus(1'b0, 1'b1, 32'h48);
    applyStimulus(1'b0, 1'b0, '0);
    waitForPc(32'h50, 10);
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_valid_cleared", {31'd0, id_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h60);
    applyStimulus(1'b0, 1'b0, '0);
    waitForPc(32'h64, 10);

    // PC wrap at the top of the address space, then a mid-run reset.
    doReset(32'hFFFF_FFF8);
    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    doReset(32'd500);

    // Random stalls and redirects, with halts and stall+redirect overlaps.
    for (int c = 0; c < 600; c++) begin
      bit          s;
      bit          r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 24) == 0) || (model_halted && $urandom_range(0, 4) == 0) ||
          (!model_halted && exp_q.size() < 8);
      t = (($urandom_range(0, 3) == 0) ? 32'h40 + $urandom_range(0, 20) : $urandom);
      applyStimulus(s, r, t);
    end
    applyStimulus(1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
